// File: rtl/hello_pkg.sv
// Shared types and message ROM for the hello_sequencer producer.
// Holds the FSM state type, message length and the byte lookup.
package hello_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned MSG_LEN = 15;
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  // "Hello, World!\r\n"
  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h48;
      4'd1:    return 8'h65;
      4'd2:    return 8'h6C;
      4'd3:    return 8'h6C;
      4'd4:    return 8'h6F;
      4'd5:    return 8'h2C;
      4'd6:    return 8'h20;
      4'd7:    return 8'h57;
      4'd8:    return 8'h6F;
      4'd9:    return 8'h72;
      4'd10:   return 8'h6C;
      4'd11:   return 8'h64;
      4'd12:   return 8'h21;
      4'd13:   return 8'h0D;
      4'd14:   return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/hello_sequencer.sv
// Streams "Hello, World!\r\n" one byte at a time on a wr/busy handshake.
// Ports: i_clk, i_reset_n, i_start, i_busy in; o_wr, o_data, o_active, o_done out.
module hello_sequencer #(
  parameter logic [23:0] PAUSE_CLKS  = 24'd12_000_000,
  parameter logic        AUTO_REPEAT = 1'b1,
  parameter logic        AUTO_START  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_busy,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_active,
  output logic       o_done
);

  import hello_pkg::*;

  state_t      state;
  state_t      state_n;
  logic [3:0]  idx;
  logic [3:0]  idx_n;
  logic [23:0] cnt;
  logic [23:0] cnt_n;
  logic        pend;
  logic        pend_n;
  logic        wr_n;
  logic [7:0]  data_n;
  logic        done_n;
  logic        active_n;
  logic        accept;

  assign accept = o_wr && !i_busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      idx      <= 4'd0;
      cnt      <= 24'd0;
      pend     <= AUTO_START;
      o_wr     <= 1'b0;
      o_data   <= 8'h00;
      o_done   <= 1'b0;
      o_active <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      pend     <= pend_n;
      o_wr     <= wr_n;
      o_data   <= data_n;
      o_done   <= done_n;
      o_active <= active_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    pend_n  = pend;
    wr_n    = o_wr;
    data_n  = o_data;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        wr_n = 1'b0;
        if (i_start || pend) begin
          state_n = SEND;
          idx_n   = 4'd0;
          data_n  = msg_byte(4'd0);
          wr_n    = 1'b1;
          pend_n  = 1'b0;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            wr_n    = 1'b0;
            done_n  = 1'b1;
            cnt_n   = PAUSE_CLKS - 24'd1;
            state_n = PAUSE;
          end else begin
            idx_n  = idx + 4'd1;
            data_n = msg_byte(idx + 4'd1);
          end
        end
      end
      PAUSE: begin
        wr_n = 1'b0;
        if (cnt == 24'd0) begin
          if (AUTO_REPEAT) begin
            state_n = SEND;
            idx_n   = 4'd0;
            data_n  = msg_byte(4'd0);
            wr_n    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 24'd1;
        end
      end
      default: begin
        state_n = IDLE;
        wr_n    = 1'b0;
      end
    endcase
    // Registered so o_active tracks the state it is entering.
    active_n = (state_n != IDLE);
  end

`ifdef FORMAL
  logic f_past_valid;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) f_past_valid <= 1'b0;
    else            f_past_valid <= 1'b1;
  end

  always @(posedge i_clk) begin
    if (f_past_valid && i_reset_n && $past(i_reset_n)) begin
      if ($past(o_wr && i_busy))
        assert (o_data == $past(o_data));
      if (o_done)
        assert ($past(accept && (idx == LAST_IDX)));
    end
    assert (idx <= LAST_IDX);
    if (o_wr)
      assert (state == SEND);
  end
`endif

endmodule

// File: tb/tb_hello_sequencer.sv
// Self-checking bench for hello_sequencer.
// Two instances: auto start/repeat (A) and start-pulse/one-shot (B).
module tb_hello_sequencer;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       man_busy = 1'b0;
  logic       mdl_busy = 1'b0;
  logic       use_mdl = 1'b0;
  logic       busy_a;
  logic       busy_b = 1'b0;
  logic       wr_a, wr_b;
  logic [7:0] data_a, data_b;
  logic       act_a, act_b;
  logic       done_a, done_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg [15] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F,
                           8'h2C, 8'h20, 8'h57, 8'h6F, 8'h72,
                           8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  assign busy_a = use_mdl ? mdl_busy : man_busy;

  hello_sequencer #(
    .PAUSE_CLKS (24'd4),
    .AUTO_REPEAT(1'b1),
    .AUTO_START (1'b1)
  ) dut_a (
    .i_clk    (clk),
    .i_reset_n(rst_a),
    .i_start  (start_a),
    .i_busy   (busy_a),
    .o_wr     (wr_a),
    .o_data   (data_a),
    .o_active (act_a),
    .o_done   (done_a)
  );

  hello_sequencer #(
    .PAUSE_CLKS (24'd3),
    .AUTO_REPEAT(1'b0),
    .AUTO_START (1'b0)
  ) dut_b (
    .i_clk    (clk),
    .i_reset_n(rst_b),
    .i_start  (start_b),
    .i_busy   (busy_b),
    .o_wr     (wr_b),
    .o_data   (data_b),
    .o_active (act_b),
    .o_done   (done_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // txuart-like busy: rises on the accept edge, stays high a random time.
  int bcnt = 0;
  always @(posedge clk) begin
    if (!use_mdl) begin
      bcnt     <= 0;
      mdl_busy <= 1'b0;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else if (bcnt == 1) begin
      bcnt     <= 0;
      mdl_busy <= 1'b0;
    end else if (wr_a && !busy_a) begin
      bcnt     <= int'($urandom_range(1, 10));
      mdl_busy <= 1'b1;
    end
  end

  // Scoreboard: expected stream is msg[] repeated, one accept per byte,
  // done once per message, exactly 4 idle clocks before the next message.
  int         acc = 0;
  int         low = 0;
  bit         gap_arm = 0;
  logic       p_wr = 1'b0;
  logic       p_busy = 1'b0;
  logic       p_done = 1'b0;
  logic [7:0] p_data = 8'h00;

  always @(negedge clk) begin
    if (use_mdl) begin
      if (p_wr && p_busy && wr_a)
        chk("hold_stable", data_a, p_data);
      if (done_a) begin
        chk("done_at_msg_end", acc % 15, 0);
        chk("done_one_cycle", p_done, 0);
        gap_arm = 1;
        low = 0;
      end
      if (gap_arm && !wr_a) low++;
      if (gap_arm && wr_a) begin
        chk("pause_len", low, 4);
        gap_arm = 0;
      end
      if (wr_a && !busy_a) begin
        chk("byte_order", data_a, msg[acc % 15]);
        acc++;
      end
    end
    p_wr   = wr_a;
    p_busy = busy_a;
    p_done = done_a;
    p_data = data_a;
  end

  typedef struct {
    logic       busy;
    logic       start;
    logic       wr;
    logic [7:0] data;
    logic       done;
    logic       active;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int bad;

    // Busy held low: 15 back-to-back bytes, 4 clocks of pause, then 'H'.
    for (int i = 0; i < 20; i++) begin
      tbl[i].busy   = 1'b0;
      tbl[i].start  = 1'b0;
      tbl[i].active = 1'b1;
      tbl[i].done   = (i == 15);
      tbl[i].wr     = (i < 15) || (i == 19);
      tbl[i].data   = (i < 15) ? msg[i] : 8'h48;
    end

    // Reset state
    tick;
    tick;
    chk("rst_wr", wr_a, 0);
    chk("rst_data", data_a, 8'h00);
    chk("rst_done", done_a, 0);
    chk("rst_active", act_a, 0);
    rst_a = 1'b1;

    for (int i = 0; i < 20; i++) begin
      man_busy = tbl[i].busy;
      start_a  = tbl[i].start;
      tick;
      chk($sformatf("vec%0d_wr", i), wr_a, tbl[i].wr);
      chk($sformatf("vec%0d_done", i), done_a, tbl[i].done);
      chk($sformatf("vec%0d_act", i), act_a, tbl[i].active);
      if (tbl[i].wr)
        chk($sformatf("vec%0d_data", i), data_a, tbl[i].data);
    end

    // Busy stall at idx 3, ignored start at idx 5, reset at idx 7.
    rst_a = 1'b0;
    tick;
    rst_a = 1'b1;
    man_busy = 1'b0;
    tick;
    chk("restart_h", data_a, 8'h48);
    repeat (3) tick;
    chk("idx3", data_a, 8'h6C);
    man_busy = 1'b1;
    bad = 0;
    repeat (50) begin
      tick;
      if (!(wr_a === 1'b1 && data_a === 8'h6C)) bad++;
    end
    chk("stall_hold_cycles_bad", bad, 0);
    man_busy = 1'b0;
    tick;
    chk("after_stall", data_a, 8'h6F);
    tick;
    chk("idx5", data_a, 8'h2C);
    man_busy = 1'b1;
    start_a  = 1'b1;
    tick;
    start_a = 1'b0;
    chk("start_ignored_wr", wr_a, 1);
    chk("start_ignored_data", data_a, 8'h2C);
    man_busy = 1'b0;
    tick;
    chk("idx6", data_a, 8'h20);
    tick;
    chk("idx7", data_a, 8'h57);
    rst_a = 1'b0;
    #1;
    chk("async_rst_wr", wr_a, 0);
    chk("async_rst_data", data_a, 8'h00);
    tick;
    rst_a = 1'b1;
    tick;
    chk("post_rst_wr", wr_a, 1);
    chk("post_rst_data", data_a, 8'h48);

    // Random txuart-like busy against the scoreboard, 3 messages.
    rst_a = 1'b0;
    tick;
    use_mdl = 1'b1;
    rst_a = 1'b1;
    for (int c = 0; c < 3000 && acc < 45; c++) tick;
    chk("random_accepts_reached", acc >= 45, 1);
    use_mdl = 1'b0;

    // B: no auto start, one-shot.
    tick;
    rst_b = 1'b1;
    bad = 0;
    repeat (100) begin
      tick;
      if (wr_b !== 1'b0) bad++;
    end
    chk("b_idle_wr_cycles", bad, 0);
    chk("b_idle_active", act_b, 0);
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    chk("b_start_wr", wr_b, 1);
    chk("b_start_data", data_b, 8'h48);
    chk("b_start_active", act_b, 1);
    for (int i = 1; i < 15; i++) begin
      tick;
      chk($sformatf("b_byte%0d", i), data_b, msg[i]);
    end
    tick;
    chk("b_done", done_b, 1);
    chk("b_done_wr", wr_b, 0);
    tick;
    tick;
    chk("b_pause_active", act_b, 1);
    chk("b_pause_done", done_b, 0);
    tick;
    chk("b_idle_again_active", act_b, 0);
    bad = 0;
    repeat (20) begin
      tick;
      if (wr_b !== 1'b0 || act_b !== 1'b0) bad++;
    end
    chk("b_stays_idle", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
